// File: rtl/rice_core_ex_result_pipe.sv
// EX-stage result history: a DEPTH-entry shift pipeline that forwards the youngest
// matching rd to NUM_RS operands, tracks late-value (pending) entries and drives writeback.
module rice_core_ex_result_pipe #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned NUM_RS = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_enable,
   input  logic                     i_stall,
   input  logic                     i_result_valid,
   input  logic [4:0]               i_result_rd,
   input  logic [XLEN-1:0]          i_result_value,
   input  logic                     i_result_pending,
   input  logic                     i_fill_valid,
   input  logic [XLEN-1:0]          i_fill_value,
   input  logic [NUM_RS*5-1:0]      i_rs,
   input  logic [NUM_RS*XLEN-1:0]   i_rs_value,
   output logic [NUM_RS*XLEN-1:0]   o_rs_value,
   output logic [NUM_RS-1:0]        o_rs_hazard,
   output logic                     o_stall_req,
   output logic                     o_wb_valid,
   output logic [4:0]               o_wb_rd,
   output logic [XLEN-1:0]          o_wb_value
);

   typedef struct packed {
      logic            valid;
      logic            pending;
      logic [4:0]      rd;
      logic [XLEN-1:0] value;
   } entry_t;

   entry_t ent_q   [DEPTH];
   entry_t ent_eff [DEPTH];
   logic   advance;
   logic   tail_stall;

   // Every consumer (forwarding, stall, writeback, shift) sees the entries with
   // this cycle's fill already applied, which yields the fill bypass for free.
   always_comb begin : fill_view
      logic found;
      found = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         ent_eff[k] = ent_q[k];
         if (i_fill_valid && !found && ent_q[k].pending) begin
            ent_eff[k].value   = i_fill_value;
            ent_eff[k].pending = 1'b0;
            found              = 1'b1;
         end
      end
   end

   always_comb begin : forward
      logic       matched;
      logic [4:0] rs;
      o_rs_value  = i_rs_value;
      o_rs_hazard = '0;
      matched     = 1'b0;
      rs          = '0;
      for (int unsigned p = 0; p < NUM_RS; p++) begin
         rs      = i_rs[p*5 +: 5];
         matched = 1'b0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!matched && rs != 5'd0 && ent_eff[k].valid && ent_eff[k].rd == rs) begin
               matched = 1'b1;
               if (ent_eff[k].pending)
                  o_rs_hazard[p] = 1'b1;
               else
                  o_rs_value[p*XLEN +: XLEN] = ent_eff[k].value;
            end
         end
      end
   end

   assign tail_stall  = ent_eff[DEPTH-1].valid && ent_eff[DEPTH-1].pending;
   assign o_stall_req = (|o_rs_hazard) || tail_stall;
   assign advance     = i_enable && !i_stall && !o_stall_req;

   always_comb begin
      o_wb_valid = advance && ent_eff[DEPTH-1].valid && !ent_eff[DEPTH-1].pending &&
                   (ent_eff[DEPTH-1].rd != 5'd0);
      o_wb_rd    = o_wb_valid ? ent_eff[DEPTH-1].rd    : '0;
      o_wb_value = o_wb_valid ? ent_eff[DEPTH-1].value : '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_enable) begin
         for (int unsigned k = 0; k < DEPTH; k++)
            ent_q[k] <= '0;
      end else if (advance) begin
         for (int unsigned k = 1; k < DEPTH; k++)
            ent_q[k] <= ent_eff[k-1];
         ent_q[0] <= '{valid:   i_result_valid,
                       pending: i_result_valid && i_result_pending,
                       rd:      i_result_rd,
                       value:   i_result_value};
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++)
            ent_q[k] <= ent_eff[k];
      end
   end

endmodule

// File: tb/tb_rice_core_ex_result_pipe.sv
// Scoreboard bench for rice_core_ex_result_pipe (XLEN=32, DEPTH=2, NUM_RS=2):
// stimulus queues expected forwarding/writeback results, a negedge monitor checks them.
module tb_rice_core_ex_result_pipe;

   logic        clk;
   logic        rst, enable, stall;
   logic        rv, rp;
   logic [4:0]  rrd;
   logic [31:0] rval;
   logic        fv;
   logic [31:0] fval;
   logic [9:0]  rs;
   logic [63:0] rs_value;
   logic [63:0] rs_out;
   logic [1:0]  hz;
   logic        stall_req;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_value;

   rice_core_ex_result_pipe #(.XLEN(32), .DEPTH(2), .NUM_RS(2)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_enable         (enable),
      .i_stall          (stall),
      .i_result_valid   (rv),
      .i_result_rd      (rrd),
      .i_result_value   (rval),
      .i_result_pending (rp),
      .i_fill_valid     (fv),
      .i_fill_value     (fval),
      .i_rs             (rs),
      .i_rs_value       (rs_value),
      .o_rs_value       (rs_out),
      .o_rs_hazard      (hz),
      .o_stall_req      (stall_req),
      .o_wb_valid       (wb_valid),
      .o_wb_rd          (wb_rd),
      .o_wb_value       (wb_value)
   );

   typedef struct {
      int          id;
      logic [31:0] v0;
      logic [31:0] v1;
      logic [1:0]  hz;
      logic        st;
   } probe_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] value;
   } wb_t;

   probe_t probe_q [$];
   wb_t    wb_q    [$];
   logic   probe;
   int     probe_id;
   int     vectors;
   int     miscompares;
   probe_t pe;
   wb_t    we;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: writeback strobes pop the writeback queue, probes pop the forwarding queue.
   always @(negedge clk) begin
      if (wb_valid) begin
         vectors++;
         if (wb_q.size() == 0) begin
            miscompares++;
            $display("FAIL wb_unexpected got rd=%0d value=%h required no writeback", wb_rd, wb_value);
         end else begin
            we = wb_q.pop_front();
            if (wb_rd !== we.rd || wb_value !== we.value) begin
               miscompares++;
               $display("FAIL wb_data got rd=%0d value=%h required rd=%0d value=%h",
                        wb_rd, wb_value, we.rd, we.value);
            end
         end
      end else if (!rst) begin
         vectors++;
         if (wb_rd !== 5'd0 || wb_value !== 32'd0) begin
            miscompares++;
            $display("FAIL wb_idle_zero got rd=%0d value=%h required 0/0", wb_rd, wb_value);
         end
      end else begin
         vectors++;
         if (wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wb_in_reset got %b required 0", wb_valid);
         end
      end
      if (probe) begin
         vectors++;
         if (probe_q.size() == 0) begin
            miscompares++;
            $display("FAIL probe_queue got empty required entry");
         end else begin
            pe = probe_q.pop_front();
            if (rs_out[31:0] !== pe.v0 || rs_out[63:32] !== pe.v1 ||
                hz !== pe.hz || stall_req !== pe.st) begin
               miscompares++;
               $display("FAIL fwd_%0d got rs0=%h rs1=%h hz=%b stall=%b required rs0=%h rs1=%h hz=%b stall=%b",
                        pe.id, rs_out[31:0], rs_out[63:32], hz, stall_req,
                        pe.v0, pe.v1, pe.hz, pe.st);
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
      probe = 1'b0;
   endtask

   task automatic expect_fwd(input logic [31:0] v0, input logic [31:0] v1,
                             input logic [1:0] h, input logic s);
      probe_t p;
      p.id = probe_id; p.v0 = v0; p.v1 = v1; p.hz = h; p.st = s;
      probe_id++;
      probe_q.push_back(p);
      probe = 1'b1;
   endtask

   task automatic exp_wb(input logic [4:0] rd, input logic [31:0] v);
      wb_t w;
      w.rd = rd; w.value = v;
      wb_q.push_back(w);
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] v, input logic pend);
      rv = 1'b1; rrd = rd; rval = v; rp = pend;
   endtask

   task automatic nopush();
      rv = 1'b0; rrd = '0; rval = '0; rp = 1'b0;
   endtask

   task automatic fill(input logic [31:0] v);
      fv = 1'b1; fval = v;
   endtask

   task automatic nofill();
      fv = 1'b0; fval = '0;
   endtask

   task automatic set_rs(input logic [4:0] r0, input logic [4:0] r1,
                         input logic [31:0] v0, input logic [31:0] v1);
      rs = {r1, r0}; rs_value = {v1, v0};
   endtask

   initial begin
      vectors = 0; miscompares = 0; probe = 1'b0; probe_id = 0;
      rst = 1'b1; enable = 1'b1; stall = 1'b0;
      nopush(); nofill(); set_rs(0, 0, 32'h0, 32'h0);
      nxt();

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         enable = 1'($urandom); stall = 1'($urandom);
         push(5'($urandom), $urandom, 1'($urandom)); rv = 1'($urandom);
         fv = 1'($urandom); fval = $urandom;
         set_rs(5'($urandom), 5'($urandom), $urandom, $urandom);
         expect_fwd(rs_value[31:0], rs_value[63:32], 2'b00, 1'b0);
         nxt();
      end
      rst = 1'b0; enable = 1'b1; stall = 1'b0; nopush(); nofill(); set_rs(0, 0, 32'h0, 32'h0);
      nxt();

      // Youngest-match priority and in-order writeback
      set_rs(5, 0, 32'h99, 32'h7); push(5, 32'h11, 0); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      push(5, 32'h22, 0); expect_fwd(32'h11, 32'h7, 2'b00, 0); nxt();
      nopush(); exp_wb(5, 32'h11); expect_fwd(32'h22, 32'h7, 2'b00, 0); nxt();
      exp_wb(5, 32'h22); expect_fwd(32'h22, 32'h7, 2'b00, 0); nxt();

      // x0 destination never forwards or writes back
      push(0, 32'hFFFF_FFFF, 0); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nopush(); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();

      // Load-use hazard, freeze, fill bypass
      push(3, 32'hDEAD, 1); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      push(7, 32'h77, 0); set_rs(3, 0, 32'h99, 32'h7); expect_fwd(32'h99, 32'h7, 2'b01, 1); nxt();
      nopush(); expect_fwd(32'h99, 32'h7, 2'b01, 1); nxt();
      fill(32'hABCD); set_rs(3, 7, 32'h99, 32'h7); expect_fwd(32'hABCD, 32'h7, 2'b00, 0); nxt();
      nofill(); exp_wb(3, 32'hABCD); expect_fwd(32'hABCD, 32'h7, 2'b00, 0); nxt();

      // Pending entry at the tail
      set_rs(0, 0, 32'h99, 32'h7); push(9, 32'h0, 1); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nopush(); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      push(10, 32'h10, 0); expect_fwd(32'h99, 32'h7, 2'b00, 1); nxt();
      expect_fwd(32'h99, 32'h7, 2'b00, 1); nxt();
      fill(32'h5555); exp_wb(9, 32'h5555); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nopush(); nofill(); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      exp_wb(10, 32'h10); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();

      // Two pending entries: fill goes to the youngest first
      push(13, 32'h0, 1); nxt();
      push(14, 32'h0, 1); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nopush(); fill(32'hAAAA); set_rs(14, 13, 32'h99, 32'h7);
      expect_fwd(32'hAAAA, 32'h7, 2'b10, 1); nxt();
      fill(32'hBBBB); exp_wb(13, 32'hBBBB); expect_fwd(32'hAAAA, 32'hBBBB, 2'b00, 0); nxt();
      nofill(); exp_wb(14, 32'hAAAA); expect_fwd(32'hAAAA, 32'h7, 2'b00, 0); nxt();

      // External stall holds entries and suppresses writeback
      set_rs(20, 0, 32'h99, 32'h7); push(20, 32'h20, 0); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nopush(); stall = 1'b1; expect_fwd(32'h20, 32'h7, 2'b00, 0); nxt();
      expect_fwd(32'h20, 32'h7, 2'b00, 0); nxt();
      stall = 1'b0; expect_fwd(32'h20, 32'h7, 2'b00, 0); nxt();
      stall = 1'b1; expect_fwd(32'h20, 32'h7, 2'b00, 0); nxt();
      stall = 1'b0; exp_wb(20, 32'h20); expect_fwd(32'h20, 32'h7, 2'b00, 0); nxt();

      // Enable drop discards pending entries
      set_rs(0, 0, 32'h99, 32'h7); push(11, 32'h0, 1); nxt();
      push(12, 32'h0, 1); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nopush(); enable = 1'b0; expect_fwd(32'h99, 32'h7, 2'b00, 1); nxt();
      enable = 1'b1; fill(32'h1234); set_rs(11, 12, 32'h99, 32'h7);
      expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nofill(); expect_fwd(32'h99, 32'h7, 2'b00, 0); nxt();
      nxt(); nxt();

      vectors++;
      if (wb_q.size() != 0) begin
         miscompares++;
         $display("FAIL wb_missing got %0d outstanding required 0", wb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
